// File: rtl/mult_seq_ctrl_pkg.sv
// Shared constants and state encoding for the EXE-stage multiply sequencer.
package mult_seq_ctrl_pkg;

  localparam logic [3:0] EXE_MULT   = 4'd11;
  localparam int         WORD_LEN   = 16;
  localparam int         MULT_CNT_W = 5;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_RUN  = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

endpackage

// File: rtl/mult_seq_ctrl_dp.sv
// Shift-add datapath: accumulator, multiplicand and multiplier registers plus
// the single adder. The product is copied to its own registers on the final
// step so an aborted multiply never disturbs the last delivered result.
module mult_shift_add_dp
  import mult_seq_ctrl_pkg::*;
#(
  parameter int W = WORD_LEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         step_i,
  input  logic         last_i,
  input  logic [W-1:0] src1_i,
  input  logic [W-1:0] src2_i,
  output logic [W-1:0] prod_hi_o,
  output logic [W-1:0] prod_lo_o
);

  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [W:0]     sum;

  // Add the multiplicand into the upper half when the current multiplier bit
  // is set, then shift {carry, acc, mplier} right by one.
  always_comb begin
    sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = src1_i;
      mplier_d = src2_i;
    end else if (step_i) begin
      acc_d    = sum[W:1];
      mplier_d = {sum[0], mplier_q[W-1:1]};
      if (last_i) begin
        prod_d = {sum[W:1], sum[0], mplier_q[W-1:1]};
      end
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign prod_hi_o = prod_q[2*W-1:W];
  assign prod_lo_o = prod_q[W-1:0];

endmodule

// File: rtl/mult_seq_ctrl.sv
// EXE-stage multiply sequencer: stalls the pipeline for WORD_LEN+1 cycles
// while the shift-add datapath runs, then opens a one-cycle writeback window.
//
//   state   | meaning
//   --------+------------------------------------------------
//   MS_IDLE | waiting for a MULT in EXE; start cycle stalls
//   MS_RUN  | one multiplier bit per cycle, count runs down
//   MS_DONE | product valid, done/wb_en pulse, stall released
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int WORD_LEN = mult_seq_ctrl_pkg::WORD_LEN,
  parameter int CNT_W    = MULT_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WORD_LEN-1:0] src1,
  input  logic [WORD_LEN-1:0] src2,
  input  logic [3:0]          dest,
  input  logic                flush,
  output logic                stall,
  output logic                busy,
  output logic                done,
  output logic [WORD_LEN-1:0] prod_hi,
  output logic [WORD_LEN-1:0] prod_lo,
  output logic                wb_en,
  output logic [3:0]          wb_dest
);

  ms_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       wb_dest_q, wb_dest_d;
  logic             load, step, last;

  // Next-state, counter and strobe decode. A flush in RUN abandons the
  // multiply without stepping; a flush in DONE is too late to matter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wb_dest_d = wb_dest_q;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      MS_IDLE: begin
        if (start && !flush) begin
          load      = 1'b1;
          stall     = 1'b1;
          cnt_d     = CNT_W'(WORD_LEN - 1);
          wb_dest_d = dest;
          state_d   = MS_RUN;
        end
      end
      MS_RUN: begin
        stall = 1'b1;
        if (flush) begin
          state_d = MS_IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == '0) begin
            last    = 1'b1;
            state_d = MS_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      MS_DONE: begin
        done    = 1'b1;
        state_d = MS_IDLE;
      end
      default: state_d = MS_IDLE;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MS_IDLE;
      cnt_q     <= '0;
      wb_dest_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_dest_q <= wb_dest_d;
    end
  end

  assign busy    = (state_q != MS_IDLE);
  assign wb_en   = done;
  assign wb_dest = wb_dest_q;

  mult_shift_add_dp #(.W(WORD_LEN)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .step_i    (step),
    .last_i    (last),
    .src1_i    (src1),
    .src2_i    (src2),
    .prod_hi_o (prod_hi),
    .prod_lo_o (prod_lo)
  );

endmodule
